elelock_multi: RTL

- Parametrised successor to the two-digit electronic lock: accepts an N-digit code from a one-hot ten-key pad, checks it on an explicit enter strobe, and drives the lock output.
- Adds edge-detected key entry, an entry counter, a failed-attempt counter with timed lockout, and explicit relock.
- Sits between the debounced keypad and the lock actuator driver.

---
 rtl/elelock_multi.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/elelock_multi.sv
// N-digit keypad lock: edge-detected key entry, enter-strobe check, failed-attempt lockout.
// Define ELELOCK_AUTORELOCK_EN to relock automatically after AUTO_CYCLES cycles open.
module elelock_multi #(
    parameter int unsigned             DIGITS         = 4,
    parameter logic [DIGITS*4-1:0]     SECRET         = 16'h1357,
    parameter int unsigned             MAX_FAIL       = 3,
    parameter int unsigned             LOCKOUT_CYCLES = 1000,
    parameter int unsigned             AUTO_CYCLES    = 500
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [9:0]                   tenkey,
    input  logic                         enter,
    input  logic                         close,
    output logic                         lock,
    output logic                         lockout,
    output logic [$clog2(DIGITS+1)-1:0]  digits_in,
    output logic [3:0]                   fail_cnt
);
    localparam int unsigned DW = $clog2(DIGITS + 1);
    localparam int unsigned BW = DIGITS * 4;
    localparam int unsigned LW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

    typedef enum logic [1:0] {StLocked, StOpen, StLockout} state_e;

    state_e          state_q, state_d;
    logic            lock_q, lock_d;
    logic            lockout_q, lockout_d;
    logic [BW-1:0]   code_q, code_d;
    logic [DW-1:0]   digits_q, digits_d;
    logic [3:0]      fail_q, fail_d;
    logic [LW-1:0]   timer_q, timer_d;
    logic [9:0]      tenkey_q;
    logic            enter_q;

    logic            press;
    logic [3:0]      key_digit;
    logic            enter_edge;
    logic            match;
    logic [3:0]      fail_inc;
    logic            auto_expire;

    always_comb begin
        press     = $onehot(tenkey) && (tenkey_q == '0);
        key_digit = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (tenkey[i]) key_digit = 4'(i);
        end
        enter_edge = enter & ~enter_q;
        match      = (digits_q == DW'(DIGITS)) && (code_q == SECRET);
        fail_inc   = fail_q + 4'd1;
    end

`ifdef ELELOCK_AUTORELOCK_EN
    localparam int unsigned AW = $clog2(AUTO_CYCLES + 1);
    logic [AW-1:0] auto_q, auto_d;

    // Counter sits at zero outside OPEN, so it starts fresh on every unlock.
    always_comb begin
        auto_expire = (state_q == StOpen) && (auto_q == AW'(AUTO_CYCLES - 1));
        auto_d      = '0;
        if (state_q == StOpen && !close && !auto_expire) auto_d = auto_q + AW'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) auto_q <= '0;
        else     auto_q <= auto_d;
    end
`else
    logic unused_auto;
    assign unused_auto = ^AUTO_CYCLES;
    assign auto_expire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        lock_d    = lock_q;
        lockout_d = lockout_q;
        code_d    = code_q;
        digits_d  = digits_q;
        fail_d    = fail_q;
        timer_d   = timer_q;
        unique case (state_q)
            StLocked: begin
                // close beats enter; enter beats a simultaneous key press
                if (close) begin
                    code_d   = '1;
                    digits_d = '0;
                end else if (enter_edge) begin
                    code_d   = '1;
                    digits_d = '0;
                    if (match) begin
                        state_d = StOpen;
                        lock_d  = 1'b0;
                        fail_d  = 4'd0;
                    end else begin
                        fail_d = fail_inc;
                        if (fail_inc == 4'(MAX_FAIL)) begin
                            state_d   = StLockout;
                            lockout_d = 1'b1;
                            timer_d   = LW'(LOCKOUT_CYCLES - 1);
                        end
                    end
                end else if (press) begin
                    code_d      = code_q << 4;
                    code_d[3:0] = key_digit;
                    if (digits_q != DW'(DIGITS)) digits_d = digits_q + DW'(1);
                end
            end
            StOpen: begin
                if (close || auto_expire) begin
                    state_d  = StLocked;
                    lock_d   = 1'b1;
                    code_d   = '1;
                    digits_d = '0;
                end
            end
            StLockout: begin
                if (timer_q == '0) begin
                    state_d   = StLocked;
                    lockout_d = 1'b0;
                    fail_d    = 4'd0;
                end else begin
                    timer_d = timer_q - LW'(1);
                end
            end
            default: begin
                state_d   = StLocked;
                lock_d    = 1'b1;
                lockout_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StLocked;
            lock_q    <= 1'b1;
            lockout_q <= 1'b0;
            code_q    <= '1;
            digits_q  <= '0;
            fail_q    <= 4'd0;
            timer_q   <= '0;
            tenkey_q  <= '0;
            enter_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            lock_q    <= lock_d;
            lockout_q <= lockout_d;
            code_q    <= code_d;
            digits_q  <= digits_d;
            fail_q    <= fail_d;
            timer_q   <= timer_d;
            tenkey_q  <= tenkey;
            enter_q   <= enter;
        end
    end

    assign lock      = lock_q;
    assign lockout   = lockout_q;
    assign digits_in = digits_q;
    assign fail_cnt  = fail_q;

endmodule
